// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port (read-only) and the data port (load/store).
// One access is in flight at a time. DM has priority over IF, and a streak
// counter caps how many DM grants in a row can pass a waiting fetch.
module rv32_mem_arbiter #(
   parameter int MEM_LAT         = 1,
   parameter int ADDR_W          = 12,
   parameter int DATA_STREAK_MAX = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [3:0]        dm_be,
   input  logic [31:0]       dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [31:0]       dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STK_W = $clog2(DATA_STREAK_MAX + 1);
   localparam logic [STK_W-1:0] STREAK_MAX = STK_W'(DATA_STREAK_MAX);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
   typedef enum logic {OWN_IF, OWN_DM} owner_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [STK_W-1:0]  streak_q, streak_d;
   owner_e            owner_q, owner_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic dm_win, if_win, in_issue, in_resp;

   // Byte-offset and out-of-range address bits are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                               dm_addr[31:ADDR_W+2], dm_addr[1:0]};

   // NOTE: grants are masked by rst_n so every output is 0 while reset is held,
   // even though the request inputs and the IDLE state are combinational paths.
   assign dm_win = rst_n && dm_req && (!if_req || (streak_q != STREAK_MAX));
   assign if_win = rst_n && if_req && !dm_win;

   assign in_issue = (state_q == S_ISSUE);
   assign in_resp  = (state_q == S_RESP);

   // Arbitration, payload capture, latency countdown and next-state selection
   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      streak_d = streak_q;
      owner_d  = owner_q;
      we_d     = we_q;
      be_d     = be_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      if_gnt   = 1'b0;
      dm_gnt   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dm_win) begin
               dm_gnt  = 1'b1;
               state_d = S_ISSUE;
               owner_d = OWN_DM;
               we_d    = dm_we;
               be_d    = dm_we ? dm_be : 4'h0;
               addr_d  = dm_addr[ADDR_W+1:2];
               wdata_d = dm_we ? dm_wdata : 32'h0;
               if (!if_req) begin
                  streak_d = '0;
               end else if (streak_q != STREAK_MAX) begin
                  streak_d = streak_q + STK_W'(1);
               end
            end else if (if_win) begin
               if_gnt   = 1'b1;
               state_d  = S_ISSUE;
               owner_d  = OWN_IF;
               we_d     = 1'b0;
               be_d     = 4'h0;
               addr_d   = if_addr[ADDR_W+1:2];
               wdata_d  = 32'h0;
               streak_d = '0;
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_W'(MEM_LAT - 1);
            state_d = (MEM_LAT == 1) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Memory strobe and response steering, decoded from state and capture registers
   always_comb begin
      mem_en    = in_issue;
      mem_we    = in_issue & we_q;
      mem_be    = in_issue ? be_q : 4'h0;
      mem_addr  = in_issue ? addr_q : '0;
      mem_wdata = in_issue ? wdata_q : 32'h0;
      if_rvalid = in_resp && (owner_q == OWN_IF);
      dm_rvalid = in_resp && (owner_q == OWN_DM);
      if_rdata  = if_rvalid ? mem_rdata : 32'h0;
      dm_rdata  = (dm_rvalid && !we_q) ? mem_rdata : 32'h0;
      busy      = (state_q != S_IDLE);
   end

   // State, counters and capture registers; reset aborts any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         streak_q <= '0;
         owner_q  <= OWN_IF;
         we_q     <= 1'b0;
         be_q     <= 4'h0;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from the same
         // pre-edge values regardless of statement order.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         streak_q <= streak_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         be_q     <= be_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Testbench for rv32_mem_arbiter: one instance with MEM_LAT=1 for the basic
// timing walk-through, one with MEM_LAT=3 driven through a scoreboard that
// predicts grants, memory strobes and responses from a word-level model.
module tb_rv32_mem_arbiter;

   localparam int L3   = 3;
   localparam int AW   = 12;
   localparam int SMAX = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- MEM_LAT=3 instance ----------------
   logic          if_req, if_gnt, if_rvalid;
   logic [31:0]   if_addr, if_rdata;
   logic          dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [3:0]    dm_be;
   logic [31:0]   dm_addr, dm_wdata, dm_rdata;
   logic          mem_en, mem_we, busy;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;

   rv32_mem_arbiter #(.MEM_LAT(L3), .ADDR_W(AW), .DATA_STREAK_MAX(SMAX)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   // ---------------- MEM_LAT=1 instance ----------------
   logic          l1_if_req, l1_if_gnt, l1_if_rvalid;
   logic [31:0]   l1_if_addr, l1_if_rdata;
   logic          l1_dm_req, l1_dm_we, l1_dm_gnt, l1_dm_rvalid;
   logic [3:0]    l1_dm_be;
   logic [31:0]   l1_dm_addr, l1_dm_wdata, l1_dm_rdata;
   logic          l1_mem_en, l1_mem_we, l1_busy;
   logic [3:0]    l1_mem_be;
   logic [AW-1:0] l1_mem_addr;
   logic [31:0]   l1_mem_wdata, l1_mem_rdata;

   rv32_mem_arbiter #(.MEM_LAT(1), .ADDR_W(AW), .DATA_STREAK_MAX(SMAX)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt), .if_rvalid(l1_if_rvalid),
      .if_rdata(l1_if_rdata),
      .dm_req(l1_dm_req), .dm_we(l1_dm_we), .dm_be(l1_dm_be), .dm_addr(l1_dm_addr),
      .dm_wdata(l1_dm_wdata), .dm_gnt(l1_dm_gnt), .dm_rvalid(l1_dm_rvalid), .dm_rdata(l1_dm_rdata),
      .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_be(l1_mem_be), .mem_addr(l1_mem_addr),
      .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
   );

   // ---------------- checking helpers ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic logic [31:0] init_word(input logic [11:0] i);
      return {8'hC0, i, ~i};
   endfunction

   // ---------------- memories ----------------
   // ram3 is the physical RAM behind the MEM_LAT=3 instance; ref_mem is the
   // bench's own view, updated per transaction at grant time.
   logic [31:0] ram3    [0:4095];
   logic [31:0] ref_mem [0:4095];
   logic [31:0] pipe3   [0:L3-1];

   assign mem_rdata = pipe3[L3-1];

   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) ram3[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      pipe3[0] <= mem_en ? ram3[mem_addr] : $urandom;
      for (int s = 1; s < L3; s++) pipe3[s] <= pipe3[s-1];
   end

   always @(posedge clk) l1_mem_rdata <= l1_mem_en ? init_word(l1_mem_addr) : $urandom;

   // ---------------- scoreboard ----------------
   typedef struct { logic is_dm; logic [31:0] data; int cyc; } resp_t;
   typedef struct { logic we; logic [3:0] be; logic [AW-1:0] addr; logic [31:0] wdata; int cyc; } iss_t;

   resp_t         exp_q[$];
   iss_t          iss;
   bit            iss_pend = 1'b0;
   int            m_streak = 0;
   int            next_ok  = 0;
   int            n_dm_gnt = 0;
   int            last_if_gnt = 0;
   int            last_dm_gnt = 0;
   bit            grant_log[$];
   bit            m_idle, exp_dm;
   resp_t         r;
   logic [AW-1:0] wa;

   // Monitor: predicts grants, checks strobes and pops responses each cycle
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            iss_pend = 1'b0;
            m_streak = 0;
            next_ok  = 0;
         end else begin
            m_idle = (cyc >= next_ok);
            check("busy", busy, !m_idle);
            if (!if_rvalid) check("if_rdata_quiet", if_rdata, 32'h0);
            if (!dm_rvalid) check("dm_rdata_quiet", dm_rdata, 32'h0);
            if (dm_gnt) n_dm_gnt++;

            if (mem_en) begin
               if (!iss_pend) flag("mem_en_unexpected");
               else begin
                  iss_pend = 1'b0;
                  check("mem_en_cycle", cyc, iss.cyc);
                  check("mem_we", mem_we, iss.we);
                  check("mem_be", mem_be, iss.be);
                  check("mem_addr", mem_addr, iss.addr);
                  if (iss.we) check("mem_wdata", mem_wdata, iss.wdata);
               end
            end else if (iss_pend && cyc >= iss.cyc) begin
               iss_pend = 1'b0;
               flag("mem_en_missing");
            end

            if (if_rvalid || dm_rvalid) begin
               if (exp_q.size() == 0) flag("rvalid_unexpected");
               else begin
                  r = exp_q.pop_front();
                  check("rvalid_port", {if_rvalid, dm_rvalid}, r.is_dm ? 2'b01 : 2'b10);
                  check("rvalid_cycle", cyc, r.cyc);
                  check("rdata", r.is_dm ? dm_rdata : if_rdata, r.data);
               end
            end else if (exp_q.size() != 0 && cyc >= exp_q[0].cyc) begin
               exp_q.delete(0);
               flag("rvalid_missing");
            end

            if (m_idle && (if_req || dm_req)) begin
               exp_dm = dm_req && !(if_req && m_streak == SMAX);
               check("gnt_if", if_gnt, !exp_dm);
               check("gnt_dm", dm_gnt, exp_dm);
               grant_log.push_back(exp_dm);
               next_ok = cyc + 2 + L3;
               if (exp_dm) begin
                  last_dm_gnt = cyc;
                  wa = dm_addr[AW+1:2];
                  m_streak = if_req ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
                  iss = '{we: dm_we, be: dm_we ? dm_be : 4'h0, addr: wa, wdata: dm_wdata, cyc: cyc + 1};
                  if (dm_we) begin
                     for (int b = 0; b < 4; b++)
                        if (dm_be[b]) ref_mem[wa][8*b +: 8] = dm_wdata[8*b +: 8];
                     r = '{is_dm: 1'b1, data: 32'h0, cyc: cyc + 1 + L3};
                  end else begin
                     r = '{is_dm: 1'b1, data: ref_mem[wa], cyc: cyc + 1 + L3};
                  end
               end else begin
                  last_if_gnt = cyc;
                  m_streak = 0;
                  wa = if_addr[AW+1:2];
                  iss = '{we: 1'b0, be: 4'h0, addr: wa, wdata: 32'h0, cyc: cyc + 1};
                  r = '{is_dm: 1'b0, data: ref_mem[wa], cyc: cyc + 1 + L3};
               end
               iss_pend = 1'b1;
               exp_q.push_back(r);
            end else if (if_gnt || dm_gnt) begin
               flag("gnt_unexpected");
            end
         end
      end
   end

   // ---------------- drivers (called at posedge + 1) ----------------
   task automatic do_if(input logic [31:0] a);
      int n;
      if_req = 1'b1;
      if_addr = a;
      n = 0;
      do begin @(negedge clk); n++; end while (!if_gnt && n < 100);
      if (!if_gnt) flag("if_gnt_timeout");
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic do_dm(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
      int n;
      dm_req = 1'b1;
      dm_we = we;
      dm_be = be;
      dm_addr = a;
      dm_wdata = d;
      n = 0;
      do begin @(negedge clk); n++; end while (!dm_gnt && n < 100);
      if (!dm_gnt) flag("dm_gnt_timeout");
      @(posedge clk); #1;
      dm_req = 1'b0;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
   endtask

   // Watchdog: the run must never hang
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- directed and random sequence ----------------
   logic [5:0] pat;

   initial begin
      rst_n = 1'b0;
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
      l1_if_req = 1'b0; l1_if_addr = '0;
      l1_dm_req = 1'b0; l1_dm_we = 1'b0; l1_dm_be = '0; l1_dm_addr = '0; l1_dm_wdata = '0;
      for (int i = 0; i < 4096; i++) begin
         ram3[i]    = init_word(12'(i));
         ref_mem[i] = init_word(12'(i));
      end

      // Reset state
      @(negedge clk);
      check("rst_ctrl3", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy}, 7'h0);
      check("rst_ctrl1", {l1_if_gnt, l1_if_rvalid, l1_dm_gnt, l1_mem_en, l1_busy}, 5'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Test 1: MEM_LAT=1 fetch timing
      @(posedge clk); #1;
      l1_if_req = 1'b1; l1_if_addr = 32'h10;
      @(negedge clk);
      check("t1_gnt", l1_if_gnt, 1'b1);
      check("t1_busy_at_gnt", l1_busy, 1'b0);
      @(posedge clk); #1 l1_if_req = 1'b0;
      @(negedge clk);
      check("t1_mem_en", l1_mem_en, 1'b1);
      check("t1_mem_addr", l1_mem_addr, 12'd4);
      check("t1_mem_we", l1_mem_we, 1'b0);
      check("t1_no_gnt", l1_if_gnt, 1'b0);
      @(negedge clk);
      check("t1_rvalid", l1_if_rvalid, 1'b1);
      check("t1_rdata", l1_if_rdata, init_word(12'd4));
      @(negedge clk);
      check("t1_busy_done", l1_busy, 1'b0);
      check("t1_rvalid_off", l1_if_rvalid, 1'b0);
      check("t1_rdata_off", l1_if_rdata, 32'h0);
      @(posedge clk); #1;

      // Test 2: simultaneous requests, DM first, IF right after
      fork
         do_dm(1'b0, 4'h0, 32'h40, 32'h0);
         do_if(32'h44);
      join
      check("t2_if_after_dm", last_if_gnt - last_dm_gnt, 2 + L3);

      // Test 3: both requesting back-to-back, streak limit 2
      grant_log.delete();
      fork
         repeat (4) do_dm(1'b0, 4'h0, 32'h80, 32'h0);
         repeat (2) do_if(32'h84);
      join
      pat = '0;
      for (int i = 0; i < 6 && i < grant_log.size(); i++) pat[5-i] = grant_log[i];
      check("t3_count", grant_log.size(), 6);
      check("t3_order", pat, 6'b110110);

      // Test 4: store strobe fields, then read back
      do_dm(1'b1, 4'b0011, 32'h20, 32'hDEADBEEF);
      @(negedge clk);
      check("t4_mem_we", mem_we, 1'b1);
      check("t4_mem_be", mem_be, 4'b0011);
      check("t4_mem_addr", mem_addr, 12'd8);
      check("t4_mem_wdata", mem_wdata, 32'hDEADBEEF);
      @(posedge clk); #1;
      do_dm(1'b0, 4'h0, 32'h20, 32'h0);

      // Dropped request: DM pulses for one cycle while a fetch is in flight
      do_if(32'h100);
      n_dm_gnt = 0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
      @(posedge clk); #1 dm_req = 1'b0;
      repeat (8) @(negedge clk);
      check("drop_no_gnt", n_dm_gnt, 0);
      @(posedge clk); #1;

      // Test 5: reset during WAIT aborts the access
      do_if(32'h200);
      @(posedge clk); #1;
      rst_n = 1'b0;
      if_req = 1'b1; if_addr = 32'h88;
      #1;
      check("t5_rst_ctrl", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy}, 7'h0);
      check("t5_rst_data", |{if_rdata, dm_rdata, mem_wdata, mem_be, mem_addr}, 1'b0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      do_if(32'h88);

      // Test 6: 20 random requests from both ports
      fork
         for (int k = 0; k < 10; k++) begin
            gap();
            do_if($urandom);
         end
         for (int k = 0; k < 10; k++) begin
            gap();
            do_dm(1'($urandom), 4'($urandom),
                  {18'($urandom), 9'h0, 3'($urandom), 2'($urandom)}, $urandom);
         end
      join

      repeat (10) @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      check("issue_drained", iss_pend, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
